mem_blk_arbiter: RTL and testbench
==================================

Name: mem_blk_arbiter

Overview:
- Shares the single backing-memory block port between the instruction-cache fill path and the data-cache fill/write-back path.
- Accepts block requests from the I-side (read only) and the D-side (read or write), grants one at a time, and sequences the memory handshake.
- Returns the fetched 256-bit block and a one-cycle done pulse to the winner.
- Sits in the MIPS top between the caches and the memory ports iBlkRead/dBlkRead/dBlkWrite.

Parameters:
ADDR_W, 32, block address width
BLK_W, 256, cache block width in bits (32 bytes)
MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting (used only with the optional feature)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous reset, active-low (0 = reset)
iBlkRead_fIC  input  1  I-cache block read request, held until iBlkDone_2IC
iBlkAddr_fIC  input  ADDR_W  I-side block address
block_read_2IC  output  BLK_W  block returned to I-cache
iBlkDone_2IC  output  1  one-cycle done pulse to I-cache
dBlkRead_fDC  input  1  D-cache block read request
dBlkWrite_fDC  input  1  D-cache block write (write-back) request
dBlkAddr_fDC  input  ADDR_W  D-side block address
block_write_fDC  input  BLK_W  D-side write data
block_read_2DC  output  BLK_W  block returned to D-cache
dBlkDone_2DC  output  1  one-cycle done pulse to D-cache
blk_address_2M  output  ADDR_W  memory block address, bits [4:0] forced 0
BlkRead_2M  output  1  memory block read request
BlkWrite_2M  output  1  memory block write request
block_write_2M  output  BLK_W  memory write data
block_read_fM  input  BLK_W  memory read data
block_read_fM_valid  input  1  memory read complete
block_write_fM_valid  input  1  memory write complete
Busy  output  1  high when state is not IDLE

Behaviour:
- Reset (RESET=0, async):
  - State IDLE; all outputs 0, including both block_read buses.
  - last_grant = D; d_streak = 0.
- States: IDLE, GNT_I, GNT_D, DONE.
- IDLE: requests are sampled at the clock edge.
  - No request: stay in IDLE.
  - Only I requests: go to GNT_I.
  - Only D requests: go to GNT_D.
  - Both request: D wins (fixed D priority, because a D miss stalls MEM).
- Grant edge:
  - Latch the winner's address with [4:0] zeroed.
  - Latch the operation, and for a D write, latch block_write_fDC.
  - Outputs are driven only from these registers. Requester inputs may change after the grant with no effect.
- D-side op select: dBlkWrite_fDC has priority over dBlkRead_fDC. When both are high, the write is serviced first. The D-cache keeps read asserted and wins a later arbitration.
- GNT_I: BlkRead_2M=1. Stay until block_read_fM_valid=1, then capture block_read_fM into block_read_2IC and go to DONE.
- GNT_D read: BlkRead_2M=1; wait for block_read_fM_valid; capture into block_read_2DC.
- GNT_D write: BlkWrite_2M=1 and block_write_2M = latched data; wait for block_write_fM_valid. block_read_2DC is unchanged.
- Completion ignores the wrong-kind valid (e.g. write_valid during a read). Any valid seen in IDLE or DONE is ignored.
- DONE:
  - The matching done pulse is high for exactly this cycle. BlkRead_2M and BlkWrite_2M are 0.
  - Next state is IDLE.
  - The requester must drop its request on the edge that ends DONE. The request is not re-sampled until IDLE.
- block_read_2IC and block_read_2DC hold their last captured value until the next capture for that side.
- Minimum latency: request in cycle 0, memory request in cycle 1, valid in cycle 1 (zero-wait), done pulse in cycle 2, IDLE in cycle 3. Back-to-back grants are therefore spaced at least 3 cycles apart.
- A request deasserted mid-transaction does not abort it. The transaction completes and the done pulse is still issued.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with outputs 0 and no done pulse.
  - The memory side is expected to be reset on the same RESET.
- Bookkeeping: last_grant updates on every grant. d_streak increments on a D grant made while iBlkRead_fIC=1, saturating at MAX_D_STREAK, and clears on any I grant.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- Defined: in IDLE with both requesting, if d_streak == MAX_D_STREAK then I wins. d_streak clears on that I grant.
- Undefined: pure fixed D priority; d_streak logic is not built and MAX_D_STREAK is unused. I can starve under continuous D traffic, which is acceptable for the current single-issue core.

Test Plan:
- Reset then I read addr 0x0000_1234 with valid in the first GNT_I cycle (data 0xA5 repeated) -> blk_address_2M=0x0000_1220 and BlkRead_2M=1 in cycle 1; iBlkDone_2IC=1 in cycle 2 only; block_read_2IC=0xA5 repeated.
- I and D read asserted together, memory valid after 3 wait cycles -> D granted first; dBlkDone_2DC pulses; I granted on the next IDLE; I done follows D done by at least 3 cycles.
- D write and read both high, addr 0x100, write data 0xDEAD... -> BlkWrite_2M=1 with latched data; write_valid ends it; the read is serviced next; read_valid arriving during the write is ignored.
- RESET pulled low while in GNT_D waiting for valid -> outputs 0 and Busy=0 immediately; no done pulse; a later valid in IDLE has no effect.
- With MEM_ARB_STARVE_GUARD_EN and MAX_D_STREAK=4, I held high and D re-requesting continuously -> exactly 4 D grants then 1 I grant, repeating. Without the macro -> I is never granted.

Source files
------------

// File: rtl/mem_blk_arbiter.sv
// Arbitrates the single memory block port between I-cache and D-cache fills.
// Define MEM_ARB_STARVE_GUARD_EN to bound consecutive D grants while I waits.
module mem_blk_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int BLK_W        = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              iBlkRead_fIC,
    input  logic [ADDR_W-1:0] iBlkAddr_fIC,
    output logic [BLK_W-1:0]  block_read_2IC,
    output logic              iBlkDone_2IC,
    input  logic              dBlkRead_fDC,
    input  logic              dBlkWrite_fDC,
    input  logic [ADDR_W-1:0] dBlkAddr_fDC,
    input  logic [BLK_W-1:0]  block_write_fDC,
    output logic [BLK_W-1:0]  block_read_2DC,
    output logic              dBlkDone_2DC,
    output logic [ADDR_W-1:0] blk_address_2M,
    output logic              BlkRead_2M,
    output logic              BlkWrite_2M,
    output logic [BLK_W-1:0]  block_write_2M,
    input  logic [BLK_W-1:0]  block_read_fM,
    input  logic              block_read_fM_valid,
    input  logic              block_write_fM_valid,
    output logic              Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GNT_I,
        S_GNT_D,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-5){1'b1}}, 5'b0};

    if (MAX_D_STREAK < 1) begin : g_bad_streak
        $error("MAX_D_STREAK must be at least 1");
    end

    state_t              r_state;
    logic                r_last_d;
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd;
    logic                r_wr;
    logic [BLK_W-1:0]    r_wdata;
    logic [BLK_W-1:0]    r_rdata_i;
    logic [BLK_W-1:0]    r_rdata_d;
    logic                r_done_i;
    logic                r_done_d;

    logic                w_d_req;
    logic                w_pick_i;
    logic                w_complete;

    assign w_d_req = dBlkRead_fDC | dBlkWrite_fDC;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] r_d_streak;

    // I overrides D priority once D has won MAX_D_STREAK times in a row
    assign w_pick_i = iBlkRead_fIC & (~w_d_req | (r_d_streak == STREAK_MAX));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_d_streak <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_pick_i) begin
                r_d_streak <= '0;
            end else if (w_d_req && iBlkRead_fIC && r_d_streak != STREAK_MAX) begin
                r_d_streak <= r_d_streak + 1'b1;
            end
        end
    end
`else
    assign w_pick_i = iBlkRead_fIC & ~w_d_req;
`endif

    assign w_complete = ((r_state == S_GNT_I) || (r_state == S_GNT_D)) &&
                        (r_op_wr ? block_write_fM_valid : block_read_fM_valid);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_last_d  <= 1'b1;
            r_op_wr   <= 1'b0;
            r_addr    <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_rdata_i <= '0;
            r_rdata_d <= '0;
            r_done_i  <= 1'b0;
            r_done_d  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pick_i) begin
                        r_state  <= S_GNT_I;
                        r_last_d <= 1'b0;
                        r_op_wr  <= 1'b0;
                        r_rd     <= 1'b1;
                        r_addr   <= iBlkAddr_fIC & ADDR_MASK;
                    end else if (w_d_req) begin
                        r_state  <= S_GNT_D;
                        r_last_d <= 1'b1;
                        r_op_wr  <= dBlkWrite_fDC;
                        r_rd     <= ~dBlkWrite_fDC;
                        r_wr     <= dBlkWrite_fDC;
                        r_addr   <= dBlkAddr_fDC & ADDR_MASK;
                        if (dBlkWrite_fDC) begin
                            r_wdata <= block_write_fDC;
                        end
                    end
                end
                S_GNT_I, S_GNT_D: begin
                    if (w_complete) begin
                        r_state  <= S_DONE;
                        r_rd     <= 1'b0;
                        r_wr     <= 1'b0;
                        r_wdata  <= '0;
                        r_done_i <= ~r_last_d;
                        r_done_d <= r_last_d;
                        if (!r_op_wr) begin
                            if (r_last_d) begin
                                r_rdata_d <= block_read_fM;
                            end else begin
                                r_rdata_i <= block_read_fM;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_done_i <= 1'b0;
                    r_done_d <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign block_read_2IC = r_rdata_i;
    assign iBlkDone_2IC   = r_done_i;
    assign block_read_2DC = r_rdata_d;
    assign dBlkDone_2DC   = r_done_d;
    assign blk_address_2M = r_addr;
    assign BlkRead_2M     = r_rd;
    assign BlkWrite_2M    = r_wr;
    assign block_write_2M = r_wdata;
    assign Busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_blk_arbiter.sv
// Scoreboard bench for mem_blk_arbiter: expected memory ops and done
// responses are queued by stimulus and popped by independent monitors.
module tb_mem_blk_arbiter;

    localparam int AW = 32;
    localparam int BW = 256;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          iBlkRead_fIC = 1'b0;
    logic [AW-1:0] iBlkAddr_fIC = '0;
    logic [BW-1:0] block_read_2IC;
    logic          iBlkDone_2IC;
    logic          dBlkRead_fDC = 1'b0;
    logic          dBlkWrite_fDC = 1'b0;
    logic [AW-1:0] dBlkAddr_fDC = '0;
    logic [BW-1:0] block_write_fDC = '0;
    logic [BW-1:0] block_read_2DC;
    logic          dBlkDone_2DC;
    logic [AW-1:0] blk_address_2M;
    logic          BlkRead_2M;
    logic          BlkWrite_2M;
    logic [BW-1:0] block_write_2M;
    logic [BW-1:0] block_read_fM = '0;
    logic          block_read_fM_valid = 1'b0;
    logic          block_write_fM_valid = 1'b0;
    logic          Busy;

    mem_blk_arbiter dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .iBlkRead_fIC        (iBlkRead_fIC),
        .iBlkAddr_fIC        (iBlkAddr_fIC),
        .block_read_2IC      (block_read_2IC),
        .iBlkDone_2IC        (iBlkDone_2IC),
        .dBlkRead_fDC        (dBlkRead_fDC),
        .dBlkWrite_fDC       (dBlkWrite_fDC),
        .dBlkAddr_fDC        (dBlkAddr_fDC),
        .block_write_fDC     (block_write_fDC),
        .block_read_2DC      (block_read_2DC),
        .dBlkDone_2DC        (dBlkDone_2DC),
        .blk_address_2M      (blk_address_2M),
        .BlkRead_2M          (BlkRead_2M),
        .BlkWrite_2M         (BlkWrite_2M),
        .block_write_2M      (block_write_2M),
        .block_read_fM       (block_read_fM),
        .block_read_fM_valid (block_read_fM_valid),
        .block_write_fM_valid(block_write_fM_valid),
        .Busy                (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } mem_op_t;

    typedef struct {
        logic          d_side;
        logic [BW-1:0] data;
    } resp_t;

    mem_op_t       exp_mem[$];
    resp_t         exp_resp[$];
    logic [BW-1:0] mem_img[logic [AW-1:0]];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_grants = 0;
    int rsp_wait = 0;
    int rcnt = 0;
    bit inj_wrong = 1'b0;
    bit inj_idle = 1'b0;
    bit prev_act = 1'b0;
    logic [BW-1:0] last_d_exp = '0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] blk_at(input logic [AW-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return '0;
    endfunction

    // Memory responder: valid after rsp_wait active cycles
    always @(negedge CLK) begin
        block_read_fM_valid = 1'b0;
        block_write_fM_valid = 1'b0;
        if (BlkRead_2M) begin
            if (rcnt >= rsp_wait) begin
                block_read_fM_valid = 1'b1;
                block_read_fM = blk_at(blk_address_2M);
            end else if (inj_wrong) begin
                block_write_fM_valid = 1'b1;
            end
            rcnt++;
        end else if (BlkWrite_2M) begin
            if (rcnt >= rsp_wait) begin
                block_write_fM_valid = 1'b1;
            end else if (inj_wrong) begin
                block_read_fM_valid = 1'b1;
                block_read_fM = '1;
            end
            rcnt++;
        end else begin
            rcnt = 0;
        end
        if (inj_idle) begin
            block_read_fM_valid = 1'b1;
            block_write_fM_valid = 1'b1;
            block_read_fM = '1;
        end
    end

    // Memory-side monitor: checks each new grant against exp_mem
    always @(negedge CLK) begin
        logic act;
        mem_op_t e;
        act = BlkRead_2M | BlkWrite_2M;
        if (act && !prev_act) begin
            n_grants++;
            if (exp_mem.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mem_unexpected: got op at %0h expected none",
                         blk_address_2M);
            end else begin
                e = exp_mem.pop_front();
                chk("mem_op_wr", BW'(BlkWrite_2M), BW'(e.wr));
                chk("mem_op_rd", BW'(BlkRead_2M), BW'(!e.wr));
                chk("mem_addr", BW'(blk_address_2M), BW'(e.addr));
                if (e.wr) chk("mem_wdata", block_write_2M, e.wdata);
            end
        end
        prev_act = act;
    end

    // Response monitor: checks each done pulse against exp_resp
    always @(negedge CLK) begin
        resp_t e;
        if (iBlkDone_2IC || dBlkDone_2DC) begin
            if (exp_resp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got i=%0b d=%0b expected none",
                         iBlkDone_2IC, dBlkDone_2DC);
            end else begin
                e = exp_resp.pop_front();
                chk("done_d", BW'(dBlkDone_2DC), BW'(e.d_side));
                chk("done_i", BW'(iBlkDone_2IC), BW'(!e.d_side));
                chk("done_data", e.d_side ? block_read_2DC : block_read_2IC,
                    e.data);
            end
        end
    end

    task automatic wait_done(input bit d_side, output int at);
        at = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (d_side ? dBlkDone_2DC : iBlkDone_2IC) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no pulse expected d_side=%0b",
                     d_side);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic push_mem(input logic wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] wd);
        mem_op_t m;
        m.wr = wr;
        m.addr = a;
        m.wdata = wd;
        exp_mem.push_back(m);
    endtask

    task automatic push_resp(input logic d, input logic [BW-1:0] data);
        resp_t r;
        r.d_side = d;
        r.data = data;
        exp_resp.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int td;
        int ti;
        int base;
        bit seen;
        logic [BW-1:0] wd;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", BW'(Busy), BW'(0));
        chk("rst_rd", BW'(BlkRead_2M), BW'(0));
        chk("rst_wr", BW'(BlkWrite_2M), BW'(0));
        chk("rst_addr", BW'(blk_address_2M), BW'(0));
        chk("rst_rdata_i", block_read_2IC, '0);
        chk("rst_rdata_d", block_read_2DC, '0);
        chk("rst_wdata", block_write_2M, '0);
        chk("rst_done", BW'({iBlkDone_2IC, dBlkDone_2DC}), BW'(0));
        @(posedge CLK);
        #1 RESET = 1'b1;

        // I read, zero-wait memory
        mem_img[32'h1220] = {32{8'hA5}};
        rsp_wait = 0;
        push_mem(1'b0, 32'h1220, '0);
        push_resp(1'b0, {32{8'hA5}});
        @(posedge CLK);
        #1;
        iBlkRead_fIC = 1'b1;
        iBlkAddr_fIC = 32'h1234;
        @(negedge CLK);
        chk("t1_c0_busy", BW'(Busy), BW'(0));
        @(negedge CLK);
        chk("t1_c1_rd", BW'(BlkRead_2M), BW'(1));
        chk("t1_c1_addr", BW'(blk_address_2M), BW'(32'h1220));
        chk("t1_c1_done", BW'(iBlkDone_2IC), BW'(0));
        chk("t1_c1_busy", BW'(Busy), BW'(1));
        @(negedge CLK);
        chk("t1_c2_done", BW'(iBlkDone_2IC), BW'(1));
        chk("t1_c2_rd", BW'(BlkRead_2M), BW'(0));
        @(posedge CLK);
        #1 iBlkRead_fIC = 1'b0;
        @(negedge CLK);
        chk("t1_c3_done", BW'(iBlkDone_2IC), BW'(0));
        chk("t1_c3_busy", BW'(Busy), BW'(0));
        chk("t1_c3_hold", block_read_2IC, {32{8'hA5}});

        // I and D together, 3 wait cycles: D first
        repeat (2) @(posedge CLK);
        rsp_wait = 3;
        mem_img[32'h40] = {8{32'h0D0D_0040}};
        mem_img[32'h2000] = {8{32'h1111_2000}};
        push_mem(1'b0, 32'h40, '0);
        push_mem(1'b0, 32'h2000, '0);
        push_resp(1'b1, mem_img[32'h40]);
        push_resp(1'b0, mem_img[32'h2000]);
        last_d_exp = mem_img[32'h40];
        #1;
        iBlkRead_fIC = 1'b1;
        iBlkAddr_fIC = 32'h2004;
        dBlkRead_fDC = 1'b1;
        dBlkAddr_fDC = 32'h5F;
        fork
            begin
                wait_done(1'b1, td);
                dBlkRead_fDC = 1'b0;
            end
            begin
                wait_done(1'b0, ti);
                iBlkRead_fIC = 1'b0;
            end
        join
        n_tests++;
        if (ti - td < 3) begin
            n_fail++;
            $display("FAIL t2_spacing: got %0d expected >= 3", ti - td);
        end

        // D write and read together; wrong-kind valid injected
        repeat (2) @(posedge CLK);
        rsp_wait = 3;
        inj_wrong = 1'b1;
        wd = {8{32'hDEAD_BEEF}};
        mem_img[32'h100] = {8{32'h0100_CAFE}};
        push_mem(1'b1, 32'h100, wd);
        push_mem(1'b0, 32'h100, '0);
        push_resp(1'b1, last_d_exp);
        push_resp(1'b1, mem_img[32'h100]);
        last_d_exp = mem_img[32'h100];
        #1;
        dBlkWrite_fDC = 1'b1;
        dBlkRead_fDC = 1'b1;
        dBlkAddr_fDC = 32'h100;
        block_write_fDC = wd;
        @(negedge CLK);
        @(negedge CLK);
        chk("t3_wr", BW'(BlkWrite_2M), BW'(1));
        chk("t3_rd", BW'(BlkRead_2M), BW'(0));
        chk("t3_wdata", block_write_2M, wd);
        @(posedge CLK);
        #1;
        dBlkAddr_fDC = 32'hFFFF_FFE0;
        block_write_fDC = '1;
        @(negedge CLK);
        chk("t3_addr_latched", BW'(blk_address_2M), BW'(32'h100));
        chk("t3_wdata_latched", block_write_2M, wd);
        wait_done(1'b1, td);
        dBlkWrite_fDC = 1'b0;
        dBlkAddr_fDC = 32'h100;
        wait_done(1'b1, td);
        dBlkRead_fDC = 1'b0;
        inj_wrong = 1'b0;

        // Reset while GNT_D waits for valid
        repeat (2) @(posedge CLK);
        rsp_wait = 50;
        push_mem(1'b0, 32'h300, '0);
        #1;
        dBlkRead_fDC = 1'b1;
        dBlkAddr_fDC = 32'h300;
        repeat (3) @(negedge CLK);
        chk("t4_busy_pre", BW'(Busy), BW'(1));
        #1 RESET = 1'b0;
        #1;
        chk("t4_busy", BW'(Busy), BW'(0));
        chk("t4_rd", BW'(BlkRead_2M), BW'(0));
        chk("t4_addr", BW'(blk_address_2M), BW'(0));
        chk("t4_rdata_d", block_read_2DC, '0);
        chk("t4_rdata_i", block_read_2IC, '0);
        dBlkRead_fDC = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        rsp_wait = 0;
        last_d_exp = '0;
        inj_idle = 1'b1;
        @(posedge CLK);
        #1 inj_idle = 1'b0;
        @(negedge CLK);
        chk("t4_idle_busy", BW'(Busy), BW'(0));
        chk("t4_idle_done", BW'({iBlkDone_2IC, dBlkDone_2DC}), BW'(0));
        chk("t4_idle_rdata_d", block_read_2DC, '0);

        // Continuous I and D traffic
        repeat (2) @(posedge CLK);
        mem_img[32'h400] = {8{32'h0400_D0D0}};
        mem_img[32'h800] = {8{32'h0800_1C1C}};
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (k % 5 == 4) begin
                push_mem(1'b0, 32'h800, '0);
                push_resp(1'b0, mem_img[32'h800]);
            end else begin
                push_mem(1'b0, 32'h400, '0);
                push_resp(1'b1, mem_img[32'h400]);
            end
`else
            push_mem(1'b0, 32'h400, '0);
            push_resp(1'b1, mem_img[32'h400]);
`endif
        end
`ifndef MEM_ARB_STARVE_GUARD_EN
        push_mem(1'b0, 32'h800, '0);
        push_resp(1'b0, mem_img[32'h800]);
`endif
        base = n_grants;
        #1;
        iBlkRead_fIC = 1'b1;
        iBlkAddr_fIC = 32'h800;
        dBlkRead_fDC = 1'b1;
        dBlkAddr_fDC = 32'h400;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            #1;
            if (n_grants >= base + 10) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL t5_grants: got %0d expected 10", n_grants - base);
        end
        @(posedge CLK);
        #1;
        dBlkRead_fDC = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        iBlkRead_fIC = 1'b0;
`else
        wait_done(1'b0, ti);
        iBlkRead_fIC = 1'b0;
`endif

        repeat (10) @(negedge CLK);
        chk("mem_q_empty", BW'(exp_mem.size()), BW'(0));
        chk("resp_q_empty", BW'(exp_resp.size()), BW'(0));
        chk("end_busy", BW'(Busy), BW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
